mult_acc_stage: RTL and testbench

MULT_ACC_STAGE -- requirements
Module: mult_acc_stage

---
 rtl/mult_pkg.sv | 11 +
 rtl/mult_acc_sat.sv | 29 ++
 rtl/mult_acc_stage.sv | 95 +++++++++
 tb/tb_mult_acc_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants and FSM state type for the multiply-accumulate stage.
package mult_pkg;
    localparam int P_W       = 50;
    localparam int ACC_W_DEF = 58;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;
endpackage

// File: rtl/mult_acc_sat.sv
// Combinational sign-extended add of a product into the accumulator with overflow detect.
// MULT_ACC_SAT_EN defined: clamp on overflow; undefined: two's-complement wrap.
module mult_acc_sat
    import mult_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [P_W-1:0]   p_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);
    // One guard bit above ACC_W: overflow when it disagrees with the result sign.
    logic [ACC_W:0] raw;

    assign raw   = {acc_i[ACC_W-1], acc_i} + {{(ACC_W+1-P_W){p_i[P_W-1]}}, p_i};
    assign ovf_o = raw[ACC_W] ^ raw[ACC_W-1];

`ifdef MULT_ACC_SAT_EN
    always_comb begin
        sum_o = raw[ACC_W-1:0];
        if (ovf_o) begin
            sum_o = raw[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign sum_o = raw[ACC_W-1:0];
`endif
endmodule

// File: rtl/mult_acc_stage.sv
// Accumulates signed product beats into a group sum; result registered, valid the cycle after the last beat,
// held until accepted with one input bubble per group. Overflow policy set by MULT_ACC_SAT_EN.
module mult_acc_stage
    import mult_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P_W-1:0]   in_p,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);
    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  out_acc_q, out_acc_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic              out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]  sum;
    logic              add_ovf;

    mult_acc_sat #(
        .ACC_W (ACC_W)
    ) u_sat (
        .acc_i (acc_q),
        .p_i   (in_p),
        .sum_o (sum),
        .ovf_o (add_ovf)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        if (state_q == ST_ACC) begin
            if (in_valid) begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
                ovf_d = ovf_q | add_ovf;
                if (in_last) begin
                    state_d     = ST_HOLD;
                    out_acc_d   = acc_d;
                    out_count_d = cnt_d;
                    out_ovf_d   = ovf_d;
                end
            end
        end else if (out_ready) begin
            // Accepting the result frees the accumulator; input reopens next cycle.
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign out_acc   = out_acc_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_mult_acc_stage.sv
// Directed bench for mult_acc_stage: default-width and 50-bit instances share one input stream.
module tb_mult_acc_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [49:0] in_p = '0;

    logic        in_ready, out_valid, out_ovf;
    logic [57:0] out_acc;
    logic [15:0] out_count;
    logic        in_ready50, out_valid50, out_ovf50;
    logic [49:0] out_acc50;
    logic [15:0] out_count50;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_acc_stage dut (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
        .in_p (in_p), .in_last (in_last), .out_valid (out_valid), .out_ready (out_ready),
        .out_acc (out_acc), .out_count (out_count), .out_ovf (out_ovf)
    );

    mult_acc_stage #(.ACC_W (50), .CNT_W (16)) dut50 (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready50),
        .in_p (in_p), .in_last (in_last), .out_valid (out_valid50), .out_ready (out_ready),
        .out_acc (out_acc50), .out_count (out_count50), .out_ovf (out_ovf50)
    );

    function automatic logic [63:0] m(input longint v, input int w);
        return 64'(v) & ((64'd1 << w) - 64'd1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one beat and hold it until the edge that transfers it; returns #1 after that edge.
    task automatic send(input longint p, input logic last);
        int n;
        in_valid = 1'b1;
        in_p     = 50'(p);
        in_last  = last;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            n_err++;
            $error("FAIL ready_wait: observed in_ready=0 for %0d cycles expected 1", n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_p     = 50'($urandom);
        in_last  = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        longint exp_sum;
        longint pv;
        int     nb, n;
        logic [49:0] praw;

        // Reset state
        tick(); tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_acc", 64'(out_acc), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        rst_n = 1'b1;

        // Scenario 1: 3, -5, 7
        out_ready = 1'b1;
        send(3, 1'b0);
        send(-5, 1'b0);
        send(7, 1'b1);
        check("s1_valid", 64'(out_valid), 64'd1);
        check("s1_in_ready", 64'(in_ready), 64'd0);
        check("s1_acc", 64'(out_acc), m(5, 58));
        check("s1_count", 64'(out_count), 64'd3);
        check("s1_ovf", 64'(out_ovf), 64'd0);
        tick();
        check("s1_valid_drop", 64'(out_valid), 64'd0);
        check("s1_ready_back", 64'(in_ready), 64'd1);

        // Scenario 2: single beat of -(2^48)
        send(-(64'sd1 <<< 48), 1'b1);
        check("s2_acc", 64'(out_acc), m(-(64'sd1 <<< 48), 58));
        check("s2_count", 64'(out_count), 64'd1);
        check("s2_ovf", 64'(out_ovf), 64'd0);
        tick();

        // Scenario 3: stall in HOLD with in_valid held high
        out_ready = 1'b0;
        send(10, 1'b0);
        send(20, 1'b1);
        in_valid = 1'b1; in_p = 50'd99; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s3_in_ready", 64'(in_ready), 64'd0);
            check("s3_valid", 64'(out_valid), 64'd1);
            check("s3_acc", 64'(out_acc), m(30, 58));
            check("s3_count", 64'(out_count), 64'd2);
        end
        out_ready = 1'b1;
        tick();
        check("s3_accept_valid", 64'(out_valid), 64'd0);
        check("s3_accept_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("s3_next_valid", 64'(out_valid), 64'd1);
        check("s3_next_acc", 64'(out_acc), m(99, 58));
        check("s3_next_count", 64'(out_count), 64'd1);
        tick();

        // Scenario 4: 50-bit overflow, then the flag clears for the next group
        send(64'sd1 <<< 48, 1'b0);
        send(64'sd1 <<< 48, 1'b1);
`ifdef MULT_ACC_SAT_EN
        check("s4_acc50", 64'(out_acc50), m((64'sd1 <<< 49) - 1, 50));
`else
        check("s4_acc50", 64'(out_acc50), m(-(64'sd1 <<< 49), 50));
`endif
        check("s4_ovf50", 64'(out_ovf50), 64'd1);
        check("s4_acc58", 64'(out_acc), m(64'sd1 <<< 49, 58));
        check("s4_ovf58", 64'(out_ovf), 64'd0);
        send(64'sd1 <<< 48, 1'b0);
        send(64'sd1 <<< 48, 1'b0);
        send(-1, 1'b1);
`ifdef MULT_ACC_SAT_EN
        check("s4b_acc50", 64'(out_acc50), m((64'sd1 <<< 49) - 2, 50));
`else
        check("s4b_acc50", 64'(out_acc50), m((64'sd1 <<< 49) - 1, 50));
`endif
        check("s4b_ovf50", 64'(out_ovf50), 64'd1);
        check("s4b_count50", 64'(out_count50), 64'd3);
        send(1, 1'b1);
        check("s4c_acc50", 64'(out_acc50), m(1, 50));
        check("s4c_ovf50", 64'(out_ovf50), 64'd0);
        tick();

        // Scenario 5: reset mid-group, reset beats a simultaneous last beat, reset in HOLD
        send(5, 1'b0);
        send(6, 1'b0);
        rst_n = 1'b0;
        in_valid = 1'b1; in_p = 50'd100; in_last = 1'b1;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        check("s5_rst_valid", 64'(out_valid), 64'd0);
        check("s5_rst_acc", 64'(out_acc), 64'd0);
        check("s5_rst_count", 64'(out_count), 64'd0);
        tick();
        check("s5_no_output", 64'(out_valid), 64'd0);
        send(1, 1'b0);
        send(1, 1'b1);
        check("s5_acc", 64'(out_acc), m(2, 58));
        check("s5_count", 64'(out_count), 64'd2);
        tick();
        out_ready = 1'b0;
        send(4, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("s5_hold_rst_valid", 64'(out_valid), 64'd0);
        check("s5_hold_rst_ready", 64'(in_ready), 64'd1);

        // Scenario 6: random gaps and output backpressure against a running sum
        for (int g = 0; g < 200; g++) begin
            nb = $urandom_range(1, 4);
            exp_sum = 0;
            for (int b = 0; b < nb; b++) begin
                n = $urandom_range(0, 2);
                for (int k = 0; k < n; k++) begin
                    out_ready = 1'($urandom);
                    tick();
                end
                praw = {18'($urandom), 32'($urandom)};
                pv = longint'($signed(praw));
                exp_sum += pv;
                out_ready = 1'($urandom);
                send(pv, (b == nb - 1) ? 1'b1 : 1'b0);
            end
            check("s6_acc", 64'(out_acc), m(exp_sum, 58));
            check("s6_count", 64'(out_count), 64'(nb));
            check("s6_ovf", 64'(out_ovf), 64'd0);
            n = 0;
            while (out_valid && n < 100) begin
                out_ready = 1'($urandom);
                tick();
                n++;
            end
            if (n >= 100) begin
                n_err++;
                $error("FAIL s6_accept: observed out_valid stuck for %0d cycles expected release", n);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
